// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the unified memory-port
//                arbiter (state encoding, default widths, counter sizing).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int c_DEF_ADDR_W  = 32;
    localparam int c_DEF_DATA_W  = 32;
    localparam int c_DEF_TIMEOUT = 16;

    // Width needed to hold the values 0..timeout inclusive.
    function automatic int timeout_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch port, data port, pipeline stall and the
//                unified memory bus handled by mem_port_arbiter.
//                slave  : arbiter side
//                master : core + memory model side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int DATA_W = c_DEF_DATA_W
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    // data port
    logic              dm_re;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    // pipeline control
    logic              stall;
    // unified memory bus
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, bus_rdata, bus_ready,
        output if_rdata, dm_rdata, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, bus_rdata, bus_ready,
        input  if_rdata, dm_rdata, stall, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

endinterface
`default_nettype wire

// File: rtl/arb_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : arb_timeout_ctr
//  Description : Saturating wait counter for one bus access.
//  Ports       : clk, reset (async, active-high)
//                i_clear   - return count to 0 (has priority over enable)
//                i_enable  - count one waited cycle
//                o_expired - current cycle is the LIMIT-th waited cycle (or later)
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_timeout_ctr #(
    parameter int LIMIT = 16,
    parameter int CNT_W = 5
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count k is visible in the (k+1)-th cycle of an access, so the access
    // has been outstanding LIMIT cycles once the count reaches LIMIT-1.
    assign o_expired = (r_count >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory bus between the fetch port and
//                the data port of the pipeline. Data has fixed priority; each
//                cycle group serves the data access (if any) then the fetch
//                (if any), then spends one DONE cycle with stall low so the
//                pipeline advances exactly once. A bus access that sees no
//                bus_ready for TIMEOUT cycles is aborted, returns 0 and sets
//                the sticky bus_err flag.
//  Ports       : clk, reset (async, active-high)
//                arb (mem_port_arbiter_if.slave): fetch port, data port,
//                stall, unified bus handshake, bus_err
//                perf_stall_cycles / perf_conflicts (only with MEM_ARB_PERF_EN)
//  Options     : MEM_ARB_PERF_EN - adds stall-cycle and conflict counters
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  arb
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_conflicts
`endif
);
    localparam int TIMEOUT_W = timeout_w(TIMEOUT);

    arb_state_t        r_state;
    logic              r_dm_served;
    logic              r_if_served;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_bus_err;

    logic w_dm_req;
    logic w_in_access;
    logic w_expired;
    logic w_access_done;
    logic w_timeout;
    logic w_stall;

    assign w_dm_req      = arb.dm_re | arb.dm_we;
    assign w_in_access   = (r_state == DATA) || (r_state == FETCH);
    // A bus_ready in the expiry cycle is a normal completion.
    assign w_access_done = w_in_access && (arb.bus_ready || w_expired);
    assign w_timeout     = w_in_access && w_expired && !arb.bus_ready;

    // Reset gates stall so the pipeline is released the instant reset hits.
    assign w_stall = !reset && (r_state != DONE) &&
                     ((w_dm_req && !r_dm_served) || (arb.if_req && !r_if_served));

    // Counter sits at zero outside an access and restarts at every access
    // boundary, including the back-to-back DATA->FETCH handover.
    arb_timeout_ctr #(
        .LIMIT (TIMEOUT),
        .CNT_W (TIMEOUT_W)
    ) u_timeout_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_in_access || w_access_done),
        .i_enable  (w_in_access),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dm_served <= 1'b0;
            r_if_served <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dm_req) begin
                        r_state     <= DATA;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= arb.dm_we;   // load+store together is a store
                        r_bus_addr  <= arb.dm_addr;
                        r_bus_wdata <= arb.dm_wdata;
                    end else if (arb.if_req) begin
                        r_state    <= FETCH;
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= 1'b0;
                        r_bus_addr <= arb.if_addr;
                    end
                end
                DATA: begin
                    if (w_access_done) begin
                        r_dm_served <= 1'b1;
                        if (!r_bus_we) begin
                            r_dm_rdata <= arb.bus_ready ? arb.bus_rdata : '0;
                        end
                        if (w_timeout) begin
                            r_bus_err <= 1'b1;
                        end
                        if (arb.if_req) begin
                            // bus_req stays high: fetch starts back-to-back
                            r_state    <= FETCH;
                            r_bus_we   <= 1'b0;
                            r_bus_addr <= arb.if_addr;
                        end else begin
                            r_state   <= DONE;
                            r_bus_req <= 1'b0;
                            r_bus_we  <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (w_access_done) begin
                        r_if_served <= 1'b1;
                        r_if_rdata  <= arb.bus_ready ? arb.bus_rdata : '0;
                        if (w_timeout) begin
                            r_bus_err <= 1'b1;
                        end
                        r_state   <= DONE;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                    end
                end
                DONE: begin
                    r_dm_served <= 1'b0;
                    r_if_served <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign arb.stall     = w_stall;
    assign arb.bus_req   = r_bus_req;
    assign arb.bus_we    = r_bus_we;
    assign arb.bus_addr  = r_bus_addr;
    assign arb.bus_wdata = r_bus_wdata;
    assign arb.if_rdata  = r_if_rdata;
    assign arb.dm_rdata  = r_dm_rdata;
    assign arb.bus_err   = r_bus_err;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_conf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_conf  <= '0;
        end else begin
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            // a conflict is a data access that makes a pending fetch wait
            if ((r_state == IDLE) && w_dm_req && arb.if_req) begin
                r_perf_conf <= r_perf_conf + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_conflicts    = r_perf_conf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Each directed cycle
//                group is expanded into an expected per-cycle timeline
//                (idle cycle, one bus window per access, done cycle) and a
//                compare process checks the DUT against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arb_if ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_conflicts;
`endif

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .arb               (arb_if)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_conflicts    (perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int dut_stall_cnt = 0;

    // expected-value model
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_perf_stall = '0;
    logic [31:0] exp_perf_conf = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (arb_if.stall === 1'b1) dut_stall_cnt++;
        if (chk_en) begin
            chk("stall",    32'(arb_if.stall),   32'(exp_stall));
            chk("bus_req",  32'(arb_if.bus_req), 32'(exp_req));
            if (exp_req) begin
                chk("bus_we",   32'(arb_if.bus_we), 32'(exp_we));
                chk("bus_addr", arb_if.bus_addr,    exp_addr);
                if (exp_we) chk("bus_wdata", arb_if.bus_wdata, exp_wdata);
            end
            chk("if_rdata", arb_if.if_rdata,      exp_if_rdata);
            chk("dm_rdata", arb_if.dm_rdata,      exp_dm_rdata);
            chk("bus_err",  32'(arb_if.bus_err),  32'(exp_err));
`ifdef MEM_ARB_PERF_EN
            chk("perf_stall", perf_stall_cycles, exp_perf_stall);
            chk("perf_conf",  perf_conflicts,    exp_perf_conf);
`endif
        end
    end

    // advance one cycle; inputs for the next cycle are driven 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (exp_stall) exp_perf_stall = exp_perf_stall + 32'd1;
        #1;
    endtask

    // one bus window: held for dly cycles, ready on the next (or aborted)
    task automatic do_access(input logic is_data, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int dly, input logic [31:0] rd);
        logic tmo;
        int   ncyc;
        tmo  = (dly >= TIMEOUT);
        ncyc = tmo ? TIMEOUT : dly + 1;
        for (int k = 0; k < ncyc; k++) begin
            exp_stall = 1'b1;
            exp_req   = 1'b1;
            exp_we    = we;
            exp_addr  = addr;
            exp_wdata = wdata;
            arb_if.bus_ready = (!tmo && (k == dly));
            arb_if.bus_rdata = (k == dly) ? rd : (32'hBAD0_0000 | 32'(k));
            tick();
        end
        arb_if.bus_ready = 1'b0;
        if (tmo) exp_err = 1'b1;
        if (is_data && !we) exp_dm_rdata = tmo ? 32'h0 : rd;
        if (!is_data)       exp_if_rdata = tmo ? 32'h0 : rd;
    endtask

    task automatic run_group(input logic re, input logic we, input logic [31:0] daddr,
                             input logic [31:0] wdata, input logic ifr, input logic [31:0] iaddr,
                             input int d_dm, input int d_if,
                             input logic [31:0] rd_dm, input logic [31:0] rd_if);
        logic dreq;
        dreq = re | we;
        arb_if.dm_re     = re;
        arb_if.dm_we     = we;
        arb_if.dm_addr   = daddr;
        arb_if.dm_wdata  = wdata;
        arb_if.if_req    = ifr;
        arb_if.if_addr   = iaddr;
        arb_if.bus_ready = 1'b0;
        arb_if.bus_rdata = 32'h0;
        exp_stall = dreq | ifr;
        exp_req   = 1'b0;
        chk_en    = 1'b1;
        tick();
        if (dreq && ifr) exp_perf_conf = exp_perf_conf + 32'd1;
        if (dreq || ifr) begin
            if (dreq) do_access(1'b1, we, daddr, wdata, d_dm, rd_dm);
            if (ifr)  do_access(1'b0, 1'b0, iaddr, 32'h0, d_if, rd_if);
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        arb_if.if_req    = 1'b1;
        arb_if.if_addr   = 32'h0;
        arb_if.dm_re     = 1'b0;
        arb_if.dm_we     = 1'b0;
        arb_if.dm_addr   = 32'h0;
        arb_if.dm_wdata  = 32'h0;
        arb_if.bus_rdata = 32'h0;
        arb_if.bus_ready = 1'b0;

        // reset state (fetch request pending, stall must still be low)
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",    32'(arb_if.stall),   32'd0);
        chk("rst_bus_req",  32'(arb_if.bus_req), 32'd0);
        chk("rst_bus_we",   32'(arb_if.bus_we),  32'd0);
        chk("rst_bus_addr", arb_if.bus_addr,     32'd0);
        chk("rst_if_rdata", arb_if.if_rdata,     32'd0);
        chk("rst_dm_rdata", arb_if.dm_rdata,     32'd0);
        chk("rst_bus_err",  32'(arb_if.bus_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // fetch only
        s0 = dut_stall_cnt;
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 0, 0, 32'h0, 32'h00500093);
        chk("fetch_rdata_lit",  arb_if.if_rdata,             32'h00500093);
        chk("fetch_stall_lit",  32'(dut_stall_cnt - s0),     32'd2);

        // load + fetch
        s0 = dut_stall_cnt;
        run_group(1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 32'h104, 0, 0, 32'h11223344, 32'h00A00113);
        chk("load_rdata_lit",   arb_if.dm_rdata,             32'h11223344);
        chk("lf_if_rdata_lit",  arb_if.if_rdata,             32'h00A00113);
        chk("lf_stall_lit",     32'(dut_stall_cnt - s0),     32'd3);

        // store + fetch: dm_rdata untouched
        run_group(1'b0, 1'b1, 32'h2004, 32'hDEADBEEF, 1'b1, 32'h108, 0, 0, 32'hFFFFFFFF, 32'h00000013);
        chk("store_keep_lit",   arb_if.dm_rdata,             32'h11223344);

        // load and store together behave as a store
        run_group(1'b1, 1'b1, 32'h2008, 32'h12345678, 1'b1, 32'h10C, 0, 0, 32'hCAFEF00D, 32'h00100073);

        // slow bus on the data access
        run_group(1'b1, 1'b0, 32'h2010, 32'h0, 1'b1, 32'h110, 5, 0, 32'h0BADC0DE, 32'h00000033);
        chk("slow_err_lit",     32'(arb_if.bus_err),         32'd0);

        // ready in the last allowed cycle is still a success
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h114, 0, TIMEOUT - 1, 32'h0, 32'h55AA55AA);
        chk("edge_err_lit",     32'(arb_if.bus_err),         32'd0);
        chk("edge_rdata_lit",   arb_if.if_rdata,             32'h55AA55AA);

        // no request, then data-only group
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0);
        run_group(1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0, 2, 0, 32'h76543210, 32'h0);

        // timeout on the load, fetch still proceeds
        run_group(1'b1, 1'b0, 32'h3004, 32'h0, 1'b1, 32'h118, TIMEOUT, 0, 32'h99999999, 32'h00000093);
        chk("tmo_err_lit",      32'(arb_if.bus_err),         32'd1);
        chk("tmo_rdata_lit",    arb_if.dm_rdata,             32'h0);
        run_group(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11C, 0, 1, 32'h0, 32'h00000013);

        // asynchronous reset in the middle of a data access
        chk_en = 1'b0;
        arb_if.dm_re   = 1'b1;
        arb_if.dm_we   = 1'b0;
        arb_if.dm_addr = 32'h4000;
        arb_if.if_req  = 1'b1;
        arb_if.if_addr = 32'h200;
        @(posedge clk); #1;
        chk("mid_bus_req",      32'(arb_if.bus_req),         32'd1);
        chk("mid_bus_addr",     arb_if.bus_addr,             32'h4000);
        reset = 1'b1;
        #1;
        chk("arst_bus_req",     32'(arb_if.bus_req),         32'd0);
        chk("arst_stall",       32'(arb_if.stall),           32'd0);
        chk("arst_bus_err",     32'(arb_if.bus_err),         32'd0);
        exp_err        = 1'b0;
        exp_if_rdata   = 32'h0;
        exp_dm_rdata   = 32'h0;
        exp_perf_stall = 32'h0;
        exp_perf_conf  = 32'h0;
        #2;
        reset = 1'b0;
        run_group(1'b1, 1'b0, 32'h4000, 32'h0, 1'b1, 32'h200, 0, 0, 32'hA5A5A5A5, 32'h00000013);
        chk("post_rst_rdata_lit", arb_if.dm_rdata,           32'hA5A5A5A5);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
